// File: rtl/alu_pkg.sv
// Shared ALU definitions for the function decoder and the execute stage.
//   - ALU_Func encodings (ALU_AND .. ALU_SLT)
//   - skid-buffer state encoding
//   - width-independent per-entry status flags (the full entry type lives in the
//     execute stage because it depends on its WIDTH / REG_AW parameters)
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_XNOR = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;

  // Number of valid entries held: none, head only, head plus skid.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic zero;
    logic reg_write;
    logic illegal;
    logic ovf;
  } entry_flags_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
// Ports:
//   op_a, op_b  in   operands (two's complement)
//   alu_func    in   decoded function (ALU_* encodings from alu_pkg)
//   ovf_check   in   op is a signed add/sub that must flag overflow
//   result      out  computed result (0 for unsupported functions)
//   illegal     out  alu_func is not a supported encoding (X included)
//   ovf         out  signed overflow trap
// Build option: ALU_OVF_TRAP_EN enables overflow detection; otherwise ovf is 0
// and ovf_check is ignored.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_func,
  input  logic             ovf_check,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign lt   = $signed(op_a) < $signed(op_b);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    // Plain case: an X on alu_func falls into default and is reported illegal.
    case (alu_func)
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_XNOR: result = ~(op_a ^ op_b);
      ALU_ADD:  result = sum;
      ALU_SUB:  result = diff;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
      default:  illegal = 1'b1;
    endcase
  end

`ifdef ALU_OVF_TRAP_EN
  logic add_ovf;
  logic sub_ovf;

  // Overflow iff the operands' effective signs agree but the result sign differs.
  assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
  assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    ovf = 1'b0;
    if (ovf_check) begin
      if (alu_func == ALU_ADD) ovf = add_ovf;
      else if (alu_func == ALU_SUB) ovf = sub_ovf;
    end
  end
`else
  logic unused_ovf_check;
  assign unused_ovf_check = ovf_check;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage at the EX/MEM boundary.
// Accepts a decoded ALU op, computes it combinationally in alu_core and captures
// the result into a 2-entry skid buffer (head + skid) so in_ready depends only on
// registered state, never on out_ready.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   flush                      synchronous discard of all held entries
//   in_valid / in_ready        upstream handshake (in_ready registered)
//   ALU_Func, op_a, op_b       decoded function and operands
//   ovf_check                  signed add/sub that must flag overflow
//   rd_in, reg_write_in        destination register and writeback enable
//   out_valid / out_ready      downstream handshake
//   result, zero, rd_out,
//   reg_write_out,
//   illegal_func, ovf          head entry fields
// Build option: ALU_OVF_TRAP_EN enables the signed-overflow trap (see alu_core).
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALU_Func,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic              ovf_check,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write_out,
  output logic              illegal_func,
  output logic              ovf
);

  typedef struct packed {
    logic [WIDTH-1:0]  result;
    logic [REG_AW-1:0] rd;
    entry_flags_t      flags;
  } entry_t;

  skid_state_e state_q, state_d;
  entry_t      head_q, skid_q, head_d, new_entry;

  logic             accept;
  logic             pop;
  logic             load_head;
  logic             head_from_skid;
  logic             load_skid;
  logic [WIDTH-1:0] core_result;
  logic             core_illegal;
  logic             core_ovf;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .op_a     (op_a),
    .op_b     (op_b),
    .alu_func (ALU_Func),
    .ovf_check(ovf_check),
    .result   (core_result),
    .illegal  (core_illegal),
    .ovf      (core_ovf)
  );

  always_comb begin
    new_entry                 = '0;
    new_entry.result          = core_result;
    new_entry.rd              = rd_in;
    new_entry.flags.zero      = (core_result == '0);
    new_entry.flags.illegal   = core_illegal;
    new_entry.flags.ovf       = core_ovf;
    // Trapped or illegal ops still flow but must never write back.
    new_entry.flags.reg_write = reg_write_in & ~core_illegal & ~core_ovf;
  end

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            load_head = 1'b1;
          end
        end
        StOne: begin
          if (accept && !pop) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end else if (accept && pop) begin
            load_head = 1'b1;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_d        = StOne;
            load_head      = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  assign head_d = head_from_skid ? skid_q : new_entry;

  // Flush only empties the buffer; reset additionally zeroes the stored data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_head) head_q <= head_d;
      if (load_skid) skid_q <= new_entry;
    end
  end

  assign result        = head_q.result;
  assign zero          = head_q.flags.zero;
  assign rd_out        = head_q.rd;
  assign reg_write_out = head_q.flags.reg_write;
  assign illegal_func  = head_q.flags.illegal;
  assign ovf           = head_q.flags.ovf;

endmodule
